rou_syncbuf: RTL and testbench

- Parametrised single-clock elastic message buffer for roubus. It stores messages and their seen flag in a DEPTH-entry FIFO.
- Reports occupancy upstream through a 3-level ack code: full / almost-full / ok.
- Releases messages downstream under ack_out. An optional zero-latency bypass is available when the buffer is empty.
- Counts messages dropped on overflow. Inserted on roubus segments inside one clock domain, where the previous generation only provided cross-clock transfer.

---
 rtl/rou_pkg.sv | 20 ++
 rtl/rou_fifo_ram.sv | 24 ++
 rtl/rou_syncbuf.sv | 145 ++++++++++++++
 tb/tb_rou_syncbuf.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rou_pkg.sv
// Shared roubus constants: ack codes, the idle command and the byte-enable width rule.
package rou_pkg;

    localparam logic [2:0] ACK_FULL  = 3'd0;
    localparam logic [2:0] ACK_OK    = 3'd1;
    localparam logic [2:0] ACK_AFULL = 3'd2;

    localparam logic [1:0] CMD_IDLE  = 2'b00;

    function automatic int rou_bwid(input int dwid);
        case (dwid)
            512:     return 6;
            256:     return 5;
            128:     return 4;
            64:      return 3;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/rou_fifo_ram.sv
// DEPTH x WID register array: synchronous write, asynchronous read. Contents are not reset.
module rou_fifo_ram #(
    parameter int WID   = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WID-1:0]           wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WID-1:0]           rdata_o
);

    logic [WID-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rou_syncbuf.sv
// Single-clock elastic roubus message buffer with 3-level upstream ack,
// optional empty-buffer bypass and sticky/saturating drop statistics.
module rou_syncbuf
    import rou_pkg::*;
#(
    parameter int DWID   = 128,
    parameter int AWID   = 32,
    parameter int TWID   = 5,
    parameter int BWID   = rou_bwid(DWID),
    parameter int WID    = 2 + DWID + AWID + BWID + TWID,
    parameter int DEPTH  = 4,
    parameter int AFULL  = 1,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WID-1:0]           rou_in,
    input  logic                     rou_in_seen,
    output logic [2:0]               ack_in,
    output logic [WID-1:0]           rou_out,
    output logic                     rou_out_seen,
    input  logic [2:0]               ack_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drops,
    input  logic                     clr_stat
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drops_q, drops_d;

    logic          vin, empty, full, byp, presented;
    logic          pop, pop_mem, write, drop;
    logic [WID:0]  rd_data;

    rou_fifo_ram #(
        .WID   (WID + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (write),
        .waddr_i (wptr_q),
        .wdata_i ({rou_in_seen, rou_in}),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    // A bypassed message that is accepted at once never touches storage.
    always_comb begin
        vin       = (rou_in[1:0] != CMD_IDLE);
        empty     = (count_q == '0);
        full      = (count_q == DEPTH_C);
        byp       = (BYPASS != 0) && empty && vin;
        presented = !empty || byp;
        pop       = (ack_out != 3'd0) && presented;
        pop_mem   = pop && !empty;
        write     = vin && (!full || pop) && !(byp && pop);
        drop      = vin && full && !pop;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        drops_d = drops_q;

        if (write) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_mem) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({write, pop_mem})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the clearing cycle is counted as the first event after the clear.
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_stat) begin
                drops_d = 16'd1;
            end else if (drops_q != '1) begin
                drops_d = drops_q + 16'd1;
            end
        end else if (clr_stat) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
            drops_q <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
        end
    end

    always_comb begin
        rou_out      = '0;
        rou_out_seen = 1'b0;
        if (!rst) begin
            if (byp) begin
                rou_out      = rou_in;
                rou_out_seen = rou_in_seen;
            end else if (!empty) begin
                {rou_out_seen, rou_out} = rd_data;
            end
        end
    end

    always_comb begin
        if (rst || full) begin
            ack_in = ACK_FULL;
        end else if ((DEPTH_C - count_q) <= AFULL_C) begin
            ack_in = ACK_AFULL;
        end else begin
            ack_in = ACK_OK;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;
    assign drops    = drops_q;

endmodule

// File: tb/tb_rou_syncbuf.sv
// Bench for rou_syncbuf: a non-bypass and a bypass instance share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_rou_syncbuf;
    import rou_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int TW    = 5;
    localparam int BW    = rou_bwid(DW);
    localparam int WID   = 2 + DW + AW + BW + TW;
    localparam int DEPTH = 4;
    localparam int AFULL = 1;

    typedef logic [WID:0] ent_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [WID-1:0] rou_in;
    logic           rou_in_seen;
    logic [2:0]     ack_out;
    logic           clr_stat;

    logic [2:0]     ack_in0, ack_in1;
    logic [WID-1:0] rou_out0, rou_out1;
    logic           seen0, seen1;
    logic [2:0]     count0, count1;
    logic           ovf0, ovf1;
    logic [15:0]    drops0, drops1;

    always #5 clk = ~clk;

    rou_syncbuf #(
        .DWID(DW), .AWID(AW), .TWID(TW), .DEPTH(DEPTH), .AFULL(AFULL), .BYPASS(0)
    ) dut0 (
        .clk(clk), .rst(rst), .rou_in(rou_in), .rou_in_seen(rou_in_seen),
        .ack_in(ack_in0), .rou_out(rou_out0), .rou_out_seen(seen0),
        .ack_out(ack_out), .count(count0), .overflow(ovf0), .drops(drops0),
        .clr_stat(clr_stat)
    );

    rou_syncbuf #(
        .DWID(DW), .AWID(AW), .TWID(TW), .DEPTH(DEPTH), .AFULL(AFULL), .BYPASS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .rou_in(rou_in), .rou_in_seen(rou_in_seen),
        .ack_in(ack_in1), .rou_out(rou_out1), .rou_out_seen(seen1),
        .ack_out(ack_out), .count(count1), .overflow(ovf1), .drops(drops1),
        .clr_stat(clr_stat)
    );

    int   checks = 0;
    int   errors = 0;
    ent_t q0[$];
    ent_t q1[$];
    bit   m_ovf[2];
    int   m_drops[2];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [WID-1:0] mk(input int tag, input logic [1:0] cmd);
        logic [63:0]    r;
        logic [WID-1:0] m;
        r      = {$urandom(), $urandom()};
        m      = r[WID-1:0];
        m[6:2] = tag[4:0];
        m[1:0] = cmd;
        return m;
    endfunction

    function automatic logic [2:0] exp_ack(input int n);
        if (n == DEPTH)          return 3'd0;
        if (DEPTH - n <= AFULL)  return 3'd2;
        return 3'd1;
    endfunction

    function automatic ent_t exp_ent(input int b);
        int n;
        n = (b == 0) ? q0.size() : q1.size();
        if (n > 0) return (b == 0) ? q0[0] : q1[0];
        if (b == 1 && rou_in[1:0] != 2'b00) return {rou_in_seen, rou_in};
        return '0;
    endfunction

    task automatic model_update(input int b);
        ent_t q[$];
        bit   vin, byp, presented, pop;
        int   n;
        if (b == 0) q = q0; else q = q1;
        n         = q.size();
        vin       = (rou_in[1:0] != 2'b00);
        byp       = (b == 1) && (n == 0) && vin;
        presented = (n > 0) || byp;
        pop       = (ack_out != 3'd0) && presented;
        if (pop && n > 0) void'(q.pop_front());
        if (vin && !(byp && pop) && (n < DEPTH || pop)) q.push_back({rou_in_seen, rou_in});
        if (vin && n == DEPTH && !pop) begin
            m_ovf[b]   = 1'b1;
            m_drops[b] = clr_stat ? 1 : ((m_drops[b] >= 65535) ? 65535 : m_drops[b] + 1);
        end else if (clr_stat) begin
            m_ovf[b]   = 1'b0;
            m_drops[b] = 0;
        end
        if (b == 0) q0 = q; else q1 = q;
    endtask

    task automatic check_all();
        ent_t e;
        e = exp_ent(0);
        check("out0",   rou_out0, e[WID-1:0]);
        check("seen0",  seen0,    e[WID]);
        check("count0", count0,   q0.size());
        check("ack0",   ack_in0,  exp_ack(q0.size()));
        check("ovf0",   ovf0,     m_ovf[0]);
        check("drops0", drops0,   m_drops[0]);
        e = exp_ent(1);
        check("out1",   rou_out1, e[WID-1:0]);
        check("seen1",  seen1,    e[WID]);
        check("count1", count1,   q1.size());
        check("ack1",   ack_in1,  exp_ack(q1.size()));
        check("ovf1",   ovf1,     m_ovf[1]);
        check("drops1", drops1,   m_drops[1]);
    endtask

    // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
    task automatic step(input bit chk);
        #4;
        if (chk) check_all();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic drive(input int tag, input logic [1:0] cmd, input logic [2:0] ack);
        rou_in      = mk(tag, cmd);
        rou_in_seen = 1'($urandom_range(0, 1));
        ack_out     = ack;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_ovf   = '{1'b0, 1'b0};
        m_drops = '{0, 0};
    endtask

    initial begin
        model_reset();
        rst      = 1'b1;
        clr_stat = 1'b0;
        drive(5, 2'b01, 3'd0);
        #1;
        check("rst_ack0", ack_in0, 3'd0);
        check("rst_out1", rou_out1, '0);
        check("rst_seen1", seen1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 2'b00, 3'd0);
        step(1);
        check("idle_ack0", ack_in0, 3'd1);
        check("idle_cnt0", count0, 3'd0);

        // Fill to full: ack goes 1,1,2 then 0.
        for (int t = 1; t <= 4; t++) begin
            drive(t, 2'b01, 3'd0);
            step(1);
            check("fill_ack0", ack_in0, (t == 4) ? 3'd0 : ((t == 3) ? 3'd2 : 3'd1));
        end
        check("fill_cnt0", count0, 3'd4);
        drive(0, 2'b00, 3'd1);
        for (int t = 1; t <= 4; t++) begin
            check("order_tag0", rou_out0[6:2], t);
            step(1);
        end
        check("drain_cnt0", count0, 3'd0);

        // Reset in the middle of traffic.
        for (int t = 1; t <= 3; t++) begin
            drive(t, 2'b10, 3'd0);
            step(1);
        end
        check("pre_rst_cnt0", count0, 3'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_cnt0", count0, 3'd0);
        check("mid_rst_out0", rou_out0, '0);
        check("mid_rst_ack0", ack_in0, 3'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(0, 2'b00, 3'd0);
        step(1);

        // Overflow then clear coincident with a drop.
        for (int t = 1; t <= 7; t++) begin
            drive(t, 2'b11, 3'd0);
            step(1);
        end
        check("ovf_flag0", ovf0, 1'b1);
        check("ovf_drops0", drops0, 16'd3);
        check("ovf_cnt0", count0, 3'd4);
        clr_stat = 1'b1;
        drive(8, 2'b01, 3'd0);
        step(1);
        check("clr_drop_ovf0", ovf0, 1'b1);
        check("clr_drop_drops0", drops0, 16'd1);
        drive(0, 2'b00, 3'd0);
        step(1);
        clr_stat = 1'b0;
        check("clr_drops0", drops0, 16'd0);

        // Write and pop together on a full buffer.
        drive(9, 2'b01, 3'd5);
        step(1);
        check("wrpop_cnt0", count0, 3'd4);
        check("wrpop_drops0", drops0, 16'd0);
        drive(0, 2'b00, 3'd1);
        for (int i = 0; i < 5; i++) step(1);

        // Bypass: consumed at once, then held and re-presented from storage.
        drive(7, 2'b01, 3'd1);
        #1;
        check("byp_tag1", rou_out1[6:2], 7);
        check("byp_cmd1", rou_out1[1:0], 2'b01);
        check("nobyp_out0", rou_out0, '0);
        step(1);
        check("byp_cnt1", count1, 3'd0);
        drive(7, 2'b01, 3'd0);
        step(1);
        drive(0, 2'b00, 3'd0);
        check("byp_hold_cnt1", count1, 3'd1);
        check("byp_hold_tag1", rou_out1[6:2], 7);
        step(1);
        drive(0, 2'b00, 3'd1);
        for (int i = 0; i < 5; i++) step(1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rou_in      = mk($urandom_range(0, 31), 2'($urandom_range(0, 3)));
            rou_in_seen = 1'($urandom_range(0, 1));
            ack_out     = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
            clr_stat    = ($urandom_range(0, 31) == 0);
            step(1);
        end
        clr_stat = 1'b0;

        // Drop counter saturation.
        drive(0, 2'b00, 3'd1);
        for (int i = 0; i < 5; i++) step(1);
        for (int i = 0; i < 65540; i++) begin
            drive(i % 32, 2'b01, 3'd0);
            step(i >= 65530);
        end
        check("sat_drops0", drops0, 16'hFFFF);
        check("sat_ovf0", ovf0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
